fadd8_reg: RTL and testbench
============================

Name: fadd8_reg

Overview:
- 8-bit binary adder with carry-in and carry-out, built as a ripple chain of 1-bit full-adder cells.
- Result and carry are registered, giving a single-cycle-latency datapath element.
- Used as the basic add primitive in the 16-bit RISC datapath; two instances chain through cout/cin to form a 16-bit adder.

Parameters:
- WIDTH, 8, operand/sum width. Only 8 is required to be supported; the parameter exists for generate-loop bounds.

Ports:
- clk  input  1  system clock; rising edge active
- rst  input  1  reset, asynchronous, active-high
- x  input  8  operand A, unsigned
- y  input  8  operand B, unsigned
- cin  input  1  carry-in
- in_valid  input  1  operands valid this cycle; capture enable
- s  output  8  registered sum bits [7:0]
- cout  output  1  registered carry-out (bit 8 of the sum)
- out_valid  output  1  s/cout hold a result captured on the previous enabled edge

Behaviour:
- Combinational core: {c8, sum} = x + y + cin, computed as an 8-stage ripple of full-adder cells.
  - Cell i: s_i = x_i ^ y_i ^ c_i; c_{i+1} = x_i&y_i | x_i&c_i | y_i&c_i.
  - c_0 = cin; c8 is the carry-out.
- Arithmetic:
  - Unsigned modulo 2^8 on s; cout carries the 9th bit.
  - No overflow flag and no signed interpretation.
  - Maximum total is 0xFF + 0xFF + 1 = 0x1FF, giving s = 0xFF and cout = 1.
- Register stage:
  - On a rising clk edge with in_valid = 1: s <= sum, cout <= c8, out_valid <= 1.
  - On a rising clk edge with in_valid = 0: s and cout hold their previous value; out_valid <= 0.
- Latency: exactly 1 clock from operand capture to visible result. There are no back-pressure or stall inputs.
- Reset:
  - While rst = 1, s = 0x00, cout = 0, out_valid = 0, independent of clk.
  - Reset asserted mid-operation discards the pending result.
  - The first capture occurs on the first rising edge after rst deasserts while in_valid = 1.
- Back-to-back operation: in_valid may stay high every cycle; each edge captures a new independent result.
- Inputs must be stable around the capture edge. No input registering is performed.

Decomposition:
- Shared package: a WIDTH constant (8) and a typedef for the 8-bit data word, reused by the 16-bit adder and the ALU.
- One sub-module: full_adder (ports a, b, ci, s, co; purely combinational).
  - fadd8_reg instantiates eight of them through a generate loop.
  - Output flops are written in fadd8_reg itself.

Test Plan:
- Reset: assert rst asynchronously while s = 0x65 → s = 0x00, cout = 0, out_valid = 0 immediately; values hold while rst stays high.
- Basic add: x = 0x00, y = 0x00, cin = 0, in_valid = 1 → after 1 edge, s = 0x00, cout = 0, out_valid = 1.
  - Then x = 0x01, y = 0x01, cin = 0 → s = 0x02, cout = 0.
- Carry-out: x = 0xC0, y = 0xA5, cin = 0 → s = 0x65, cout = 1.
  - Same operands with cin = 1 → s = 0x66, cout = 1.
- Full ripple: x = 0xFF, y = 0x00, cin = 1 → s = 0x00, cout = 1.
  - x = 0xFF, y = 0xFF, cin = 1 → s = 0xFF, cout = 1.
- Hold: capture x = 0x12, y = 0x34, cin = 0 (s = 0x46); then drop in_valid and change operands → s stays 0x46, cout stays 0, out_valid = 0.
- Random regression: 1000 random x/y/cin values with in_valid toggling randomly → compare {cout, s} against x + y + cin delayed by one cycle on enabled cycles.

Source files
------------

// File: rtl/fadd8_reg_pkg.sv
// Shared datapath constants and types for the 8-bit adder slice.
// The 16-bit adder and the ALU reuse these definitions.
package fadd8_reg_pkg;

    localparam int WIDTH = 8;

    typedef logic [WIDTH-1:0] word_t;

endpackage : fadd8_reg_pkg

// File: rtl/fadd8_reg_full_adder.sv
// One-bit full-adder cell; the ripple adder chains these through ci/co.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/fadd8_reg.sv
// Ripple-carry adder with registered sum and carry-out (one cycle of latency).
// Two instances chained through cout/cin form the 16-bit datapath adder.
module fadd8_reg #(
    parameter int WIDTH = fadd8_reg_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = cin;

    // Carry ripples from bit 0 upward; carry[WIDTH] is the 9th result bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Without a new capture the previous result stays visible.
            if (in_valid) begin
                s    <= sum;
                cout <= carry[WIDTH];
            end
        end
    end

endmodule : fadd8_reg

// File: tb/tb_fadd8_reg.sv
// Self-checking bench for fadd8_reg: directed vectors, async reset and a
// random run, with expected results queued at drive time and popped after the edge.
module tb_fadd8_reg;
    import fadd8_reg_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [8:0] res;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    word_t x;
    word_t y;
    logic  cin;
    logic  in_valid;
    word_t s;
    logic  cout;
    logic  out_valid;

    int    n_vec  = 0;
    int    n_miss = 0;
    exp_t  sb_q[$];
    logic [8:0] held;

    fadd8_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the model result, then compare after the edge.
    task automatic apply(input string tag, input word_t xa, input word_t ya,
                         input logic ca, input logic va);
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        x        = xa;
        y        = ya;
        cin      = ca;
        in_valid = va;
        if (va) held = {1'b0, xa} + {1'b0, ya} + {8'h00, ca};
        e.valid = va;
        e.res   = held;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, got_e.valid});
        check({tag, ".sum"}, {23'd0, cout, s}, {23'd0, got_e.res});
    endtask

    initial begin
        rst      = 1'b1;
        x        = '0;
        y        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;
        held     = '0;
        #1;
        check("reset.s", {24'd0, s}, 32'h00);
        check("reset.cout", {31'd0, cout}, 32'h0);
        check("reset.valid", {31'd0, out_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        apply("zero", 8'h00, 8'h00, 1'b0, 1'b1);
        apply("one_one", 8'h01, 8'h01, 1'b0, 1'b1);
        apply("carry_cin1", 8'hC0, 8'hA5, 1'b1, 1'b1);
        apply("carry_cin0", 8'hC0, 8'hA5, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with an operand pending: result discarded.
        @(negedge clk);
        x        = 8'h33;
        y        = 8'h44;
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst.s", {24'd0, s}, 32'h00);
        check("async_rst.cout", {31'd0, cout}, 32'h0);
        check("async_rst.valid", {31'd0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold.s", {24'd0, s}, 32'h00);
        check("rst_hold.cout", {31'd0, cout}, 32'h0);
        check("rst_hold.valid", {31'd0, out_valid}, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        held     = '0;

        apply("ripple_ff_00", 8'hFF, 8'h00, 1'b1, 1'b1);
        apply("max_total", 8'hFF, 8'hFF, 1'b1, 1'b1);
        apply("hold_cap", 8'h12, 8'h34, 1'b0, 1'b1);
        apply("hold_1", 8'hFF, 8'hFF, 1'b1, 1'b0);
        apply("hold_2", 8'h80, 8'h80, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            apply("random", word_t'($urandom_range(255)), word_t'($urandom_range(255)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_fadd8_reg
